vend_dispense_ctrl: RTL
=======================

Name: vend_dispense_ctrl

Overview:
- Sequences a vending transaction after coin credit has been accumulated upstream.
- Validates the product selection against its price and drives one product motor for a fixed pulse.
- Supervises the drop sensor with a timeout, then pays change coin-by-coin through a hopper handshake.
- Sits between the coin accumulator (credit source) and the product motors / change hopper.

Parameters:
- PRICE_A, 65, price of product A in cents
- PRICE_B, 70, price of product B in cents
- PRICE_C, 75, price of product C in cents
- MOTOR_CYCLES, 8, motor pulse length in clk cycles
- DROP_TIMEOUT, 32, cycles allowed in WAIT_DROP for drop_sense

Ports:
- clk  in  1  system clock
- R  in  1  reset; synchronous, active-high
- credit  in  7  accumulated credit in cents, 0..127
- credit_valid  in  1  credit is stable and usable
- sel_a  in  1  product A select
- sel_b  in  1  product B select
- sel_c  in  1  product C select
- cancel  in  1  refund request
- drop_sense  in  1  product-drop sensor
- hopper_ack  in  1  hopper has ejected the requested coin
- motor_a  out  1  motor drive, product A
- motor_b  out  1  motor drive, product B
- motor_c  out  1  motor drive, product C
- hopper_req  out  1  coin request
- hopper_coin  out  2  requested coin: 00 nickel, 01 dime, 10 quarter
- credit_clear  out  1  one-cycle pulse telling the accumulator to zero credit
- busy  out  1  high in every state except IDLE
- insufficient  out  1  one-cycle pulse: selected price exceeds credit
- fault  out  1  one-cycle pulse: drop timeout
- vend_done  out  1  one-cycle pulse: successful vend completed

Behaviour:
- All outputs are registered.
- Reset (R high at a clk edge):
  - state goes to IDLE; timers, latched credit and change register clear; all outputs 0.
  - Reset mid-transaction aborts immediately: motor and hopper_req are low after that edge, and no credit_clear is issued.
- States: IDLE, DISPENSE, WAIT_DROP, CHANGE, HOPPER_WAIT, CLEAR.
- IDLE:
  - Acts only when credit_valid=1.
  - cancel=1 with credit>0: change=credit, refund flag set, go CHANGE. cancel wins over a simultaneous select.
  - Exactly one sel_* high: latch item and credit.
    - credit < price: pulse insufficient, stay IDLE.
    - Otherwise: change = credit - price, go DISPENSE.
  - Zero or multiple sel_* high: ignored.
- DISPENSE:
  - The selected motor is high for exactly MOTOR_CYCLES consecutive cycles; then go WAIT_DROP.
  - drop_sense seen here is latched and counts as the drop.
- WAIT_DROP:
  - Drop latched or drop_sense=1: go CHANGE.
  - Timer reaches DROP_TIMEOUT cycles with no drop: pulse fault, change = latched credit (full refund), refund flag set, go CHANGE.
- CHANGE:
  - change=0: go CLEAR.
  - Otherwise select the largest coin not exceeding change: >=25 quarter, >=10 dime, >=5 nickel. Assert hopper_req with hopper_coin, go HOPPER_WAIT.
  - Remainder 1..4 is forfeited: go CLEAR.
- HOPPER_WAIT:
  - hopper_req and hopper_coin are held stable until a cycle with hopper_ack=1.
  - On that edge: subtract the coin value from change, drop hopper_req, return to CHANGE.
  - Minimum 2 cycles per coin. No hopper timeout.
- CLEAR:
  - Pulse credit_clear for 1 cycle.
  - Pulse vend_done in the same cycle only if the refund flag is clear.
  - Go IDLE.
- All sel_*, cancel and credit changes are ignored while busy.
- Arithmetic is 7-bit unsigned. Subtraction happens only when the operand is >= the subtrahend, so there is no wrap.

Test Plan:
- credit=75, sel_a, drop_sense on WAIT_DROP cycle 3 -> motor_a high 8 cycles, one dime (01), credit_clear + vend_done same cycle, fault=0.
- credit=60, sel_b -> insufficient pulses once, no motor, busy stays 0.
- credit=100, sel_c, hopper_ack delayed 5 cycles -> one quarter; hopper_req/hopper_coin=10 held stable all 5 cycles, dropped after ack.
- credit=70, sel_b, no drop_sense -> fault at WAIT_DROP cycle 32, refund quarter, quarter, dime, dime; credit_clear, vend_done=0.
- credit=40, cancel together with sel_a -> quarter, dime, nickel, no motor activity, vend_done=0.
- sel_a and sel_b together -> ignored. R asserted during HOPPER_WAIT -> next edge all outputs 0, IDLE, no credit_clear.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Vending transaction sequencer: price check, motor pulse, drop supervision
// with timeout, and coin-by-coin change payout through a hopper handshake.
module vend_dispense_ctrl #(
  parameter int PRICE_A      = 65,
  parameter int PRICE_B      = 70,
  parameter int PRICE_C      = 75,
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       R,
  input  logic [6:0] credit,
  input  logic       credit_valid,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       sel_c,
  input  logic       cancel,
  input  logic       drop_sense,
  input  logic       hopper_ack,
  output logic       motor_a,
  output logic       motor_b,
  output logic       motor_c,
  output logic       hopper_req,
  output logic [1:0] hopper_coin,
  output logic       credit_clear,
  output logic       busy,
  output logic       insufficient,
  output logic       fault,
  output logic       vend_done
);

  localparam int CNT_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DISPENSE, S_WAIT_DROP, S_CHANGE, S_HOPPER_WAIT, S_CLEAR
  } state_t;

  typedef enum logic [1:0] {ITEM_NONE, ITEM_A, ITEM_B, ITEM_C} item_t;

  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;

  function automatic logic [6:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_QUARTER: coin_value = 7'd25;
      COIN_DIME:    coin_value = 7'd10;
      default:      coin_value = 7'd5;
    endcase
  endfunction

  state_t      state_q, state_d;
  item_t       item_q, item_d;
  logic [6:0]  credit_q, credit_d;
  logic [6:0]  change_q, change_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        refund_q, refund_d;
  logic        motor_a_q, motor_a_d, motor_b_q, motor_b_d, motor_c_q, motor_c_d;
  logic        hopper_req_q, hopper_req_d;
  logic [1:0]  hopper_coin_q, hopper_coin_d;
  logic        credit_clear_q, credit_clear_d;
  logic        busy_q, busy_d;
  logic        insufficient_q, insufficient_d;
  logic        fault_q, fault_d;
  logic        vend_done_q, vend_done_d;

  item_t       sel_item;
  logic [6:0]  sel_price;
  item_t       motor_item;

  // Only a single asserted select names a product; anything else is ignored.
  always_comb begin
    sel_item  = ITEM_NONE;
    sel_price = 7'd0;
    case ({sel_a, sel_b, sel_c})
      3'b100:  begin sel_item = ITEM_A; sel_price = 7'(PRICE_A); end
      3'b010:  begin sel_item = ITEM_B; sel_price = 7'(PRICE_B); end
      3'b001:  begin sel_item = ITEM_C; sel_price = 7'(PRICE_C); end
      default: begin sel_item = ITEM_NONE; sel_price = 7'd0; end
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    item_d         = item_q;
    credit_d       = credit_q;
    change_d       = change_q;
    cnt_d          = cnt_q;
    drop_d         = drop_q;
    refund_d       = refund_q;
    hopper_req_d   = 1'b0;
    hopper_coin_d  = hopper_coin_q;
    credit_clear_d = 1'b0;
    insufficient_d = 1'b0;
    fault_d        = 1'b0;
    vend_done_d    = 1'b0;
    motor_item     = ITEM_NONE;

    case (state_q)
      S_IDLE: begin
        if (credit_valid) begin
          if (cancel && credit != 7'd0) begin
            item_d   = ITEM_NONE;
            credit_d = credit;
            change_d = credit;
            refund_d = 1'b1;
            state_d  = S_CHANGE;
          end else if (sel_item != ITEM_NONE) begin
            item_d   = sel_item;
            credit_d = credit;
            if (credit < sel_price) begin
              insufficient_d = 1'b1;
            end else begin
              change_d   = credit - sel_price;
              refund_d   = 1'b0;
              drop_d     = 1'b0;
              cnt_d      = '0;
              motor_item = sel_item;
              state_d    = S_DISPENSE;
            end
          end
        end
      end

      S_DISPENSE: begin
        if (drop_sense) drop_d = 1'b1;
        if (cnt_q == CNT_W'(MOTOR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_DROP;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          motor_item = item_q;
        end
      end

      S_WAIT_DROP: begin
        if (drop_q || drop_sense) begin
          state_d = S_CHANGE;
        end else if (cnt_q == CNT_W'(DROP_TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          change_d = credit_q;
          refund_d = 1'b1;
          state_d  = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHANGE: begin
        if (change_q >= 7'd25) begin
          hopper_req_d  = 1'b1;
          hopper_coin_d = COIN_QUARTER;
          state_d       = S_HOPPER_WAIT;
        end else if (change_q >= 7'd10) begin
          hopper_req_d  = 1'b1;
          hopper_coin_d = COIN_DIME;
          state_d       = S_HOPPER_WAIT;
        end else if (change_q >= 7'd5) begin
          hopper_req_d  = 1'b1;
          hopper_coin_d = COIN_NICKEL;
          state_d       = S_HOPPER_WAIT;
        end else begin
          // Zero change or an unpayable 1..4 cent remainder ends the payout.
          credit_clear_d = 1'b1;
          vend_done_d    = ~refund_q;
          state_d        = S_CLEAR;
        end
      end

      S_HOPPER_WAIT: begin
        hopper_req_d = 1'b1;
        if (hopper_ack) begin
          hopper_req_d = 1'b0;
          change_d     = change_q - coin_value(hopper_coin_q);
          state_d      = S_CHANGE;
        end
      end

      S_CLEAR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    motor_a_d = (motor_item == ITEM_A);
    motor_b_d = (motor_item == ITEM_B);
    motor_c_d = (motor_item == ITEM_C);
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q        <= S_IDLE;
      item_q         <= ITEM_NONE;
      credit_q       <= '0;
      change_q       <= '0;
      cnt_q          <= '0;
      drop_q         <= 1'b0;
      refund_q       <= 1'b0;
      motor_a_q      <= 1'b0;
      motor_b_q      <= 1'b0;
      motor_c_q      <= 1'b0;
      hopper_req_q   <= 1'b0;
      hopper_coin_q  <= '0;
      credit_clear_q <= 1'b0;
      busy_q         <= 1'b0;
      insufficient_q <= 1'b0;
      fault_q        <= 1'b0;
      vend_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      item_q         <= item_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      cnt_q          <= cnt_d;
      drop_q         <= drop_d;
      refund_q       <= refund_d;
      motor_a_q      <= motor_a_d;
      motor_b_q      <= motor_b_d;
      motor_c_q      <= motor_c_d;
      hopper_req_q   <= hopper_req_d;
      hopper_coin_q  <= hopper_coin_d;
      credit_clear_q <= credit_clear_d;
      busy_q         <= busy_d;
      insufficient_q <= insufficient_d;
      fault_q        <= fault_d;
      vend_done_q    <= vend_done_d;
    end
  end

  assign motor_a      = motor_a_q;
  assign motor_b      = motor_b_q;
  assign motor_c      = motor_c_q;
  assign hopper_req   = hopper_req_q;
  assign hopper_coin  = hopper_coin_q;
  assign credit_clear = credit_clear_q;
  assign busy         = busy_q;
  assign insufficient = insufficient_q;
  assign fault        = fault_q;
  assign vend_done    = vend_done_q;

endmodule
